uxn_fetch_unit: RTL

Instruction fetch stage directly upstream of uxnProcessor's decode/execute path.
- Reads instruction words from a synchronous program ROM using a PC.
- Buffers them in a small prefetch FIFO.
- Presents them to the processor over a valid/ready handshake.
- Handles control-flow redirects (JUMP/JZ/JNZ/CALL/RET) by flushing, and stops fetching after an HLT opcode.

---
 rtl/uxn_fetch_unit.sv | 103 ++++++++++
 1 files changed

// File: rtl/uxn_fetch_unit.sv
// Instruction fetch stage for uxnProcessor: drives the program ROM, buffers words
// in a small prefetch FIFO and hands them to decode over a valid/ready handshake.
module uxn_fetch_unit #(
  parameter int          ADDR_W  = 8,
  parameter int          INSTR_W = 18,
  parameter int          DEPTH   = 2,
  parameter logic [7:0]  HLT_OP  = 8'h70
) (
  input  logic               clk,
  input  logic               rst,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rd_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {RUN, STOP, HALT} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   inflight_pc;
  logic                inflight;
  logic [INSTR_W-1:0]  fifo_instr [DEPTH];
  logic [ADDR_W-1:0]   fifo_pc    [DEPTH];
  logic [PW-1:0]       rd_ptr, wr_ptr;
  logic [CW-1:0]       count;
  logic [CW:0]         occ;
  logic                pop, wr, issue;
  logic                rsp_is_hlt, head_is_hlt;

  assign instr_valid = (count != '0);
  assign instr       = fifo_instr[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];
  assign pop         = instr_valid & instr_ready;
  assign occ         = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign rsp_is_hlt  = (mem_rd_data[INSTR_W-1 -: 8] == HLT_OP);
  assign head_is_hlt = (instr[INSTR_W-1 -: 8] == HLT_OP);
  assign mem_rd_en   = issue;
  assign mem_addr    = pc;

  always_comb begin
    state_nxt = state;
    halted    = (state == HALT);
    // Responses are only accepted while running; in STOP they belong to words past HLT.
    wr        = inflight && (state == RUN) && !redirect_valid;
    issue     = !rst && (state == RUN) && !redirect_valid && (occ < (CW+1)'(DEPTH));
    if (redirect_valid) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN:     if (wr && rsp_is_hlt) state_nxt = STOP;
        STOP:    if (pop && head_is_hlt) state_nxt = HALT;
        HALT:    state_nxt = HALT;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= '0;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (issue) inflight_pc <= pc;
      if (redirect_valid)  pc <= redirect_pc;
      else if (issue)      pc <= pc + 1'b1;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr) begin
          fifo_instr[wr_ptr] <= mem_rd_data;
          fifo_pc[wr_ptr]    <= inflight_pc;
          wr_ptr             <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(wr) - CW'(pop);
      end
    end
  end

endmodule
